level_monitor: RTL
==================

LEVEL_MONITOR -- requirements
Module: level_monitor

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: level_valid  in  1  level sample qualifier, driven from the upstream counter's update strobe.
REQ-004 SHALL have ports: level  in  4  unsigned occupancy sample, taken from the upstream counter's value_next.
REQ-005 SHALL have ports: hi_mark  in  4  high watermark, quasi-static.
REQ-006 SHALL have ports: lo_mark  in  4  low watermark, quasi-static.
REQ-007 SHALL have ports: dwell  in  2  persistence; a transition needs dwell+1 consecutive qualifying samples (1..4).
REQ-008 SHALL have ports: clr  in  1  clears irq.
REQ-009 SHALL have ports: state  out  2  00 MID, 01 HIGH, 10 LOW; 11 never driven.
REQ-010 SHALL have ports: irq  out  1  sticky event flag.
REQ-011 SHALL have ports: peak  out  4  maximum accepted level (LEVEL_MONITOR_PEAK_EN only).

Function
REQ-012 SHALL treat a sample as accepted only when level_valid=1; non-valid cycles leave all state, streak and flags unchanged (streaks held, not cleared).
REQ-013 SHALL define qualifying conditions per accepted sample: hi_q = level >= hi_mark; lo_q = level <= lo_mark; exit_hi = level < hi_mark; exit_lo = level > lo_mark.
REQ-014 SHALL keep one 2-bit streak counter plus a 1-bit streak target (toward HIGH or toward LOW/MID), saturating at 3.
REQ-015 In MID: hi_q accepted -> streak toward HIGH; lo_q accepted -> streak toward LOW; if both true, hi_q SHALL win; neither -> streak cleared to 0.
REQ-016 SHALL clear the streak to 0 (before counting the current sample as 1) when the qualifying target differs from the stored target.
REQ-017 SHALL transition when the current accepted sample makes the streak equal dwell+1; state SHALL update on the clock edge that captures that sample (one-cycle latency: dwell=0 sample at cycle N -> state visible N+1).
REQ-018 In HIGH: exit_hi accepted counts toward MID; otherwise the streak is cleared; reaching dwell+1 -> MID.
REQ-019 In LOW: exit_lo accepted counts toward MID; otherwise the streak is cleared; reaching dwell+1 -> MID.
REQ-020 SHALL permit no direct HIGH<->LOW transition; MID is always traversed.
REQ-021 SHALL clear the streak on every state transition.
REQ-022 SHALL set irq on the edge entering HIGH or LOW (not MID); irq holds until clr.
REQ-023 SHALL give set priority over clr when both occur on the same edge.
REQ-024 SHALL apply a dwell change immediately to the comparison; a streak already >= new dwell+1 SHALL transition on the next accepted qualifying sample.
REQ-025 SHALL register all outputs; no combinational input-to-output path.

Reset
REQ-026 rst_n low SHALL asynchronously force state=MID, streak=0, irq=0, peak=0; release is synchronous to clk.
REQ-027 Reset mid-streak SHALL discard partial progress; the first post-reset accepted sample starts a new streak.

Configuration
REQ-028 Macro LEVEL_MONITOR_PEAK_EN defined: peak register updates to level when an accepted level > peak; clr additionally sets peak to 0, except that an accepted level on the same edge loads peak=level.
REQ-029 LEVEL_MONITOR_PEAK_EN undefined: the peak port and register SHALL be absent; all other behaviour is identical.

Verification
REQ-030 hi_mark=12, lo_mark=3, dwell=0; one valid sample level=12 -> state=01, irq=1 the next cycle.
REQ-031 dwell=2, hi_mark=10; valid levels 11,11,9,11,11,11 -> state stays 00 through the 9 and becomes 01 only after the third 11 of the final run.
REQ-032 In HIGH with hi_mark=10, dwell=1; samples 9, valid low for 5 cycles, then 8 -> state=00 after the 8, with the streak held across the idle cycles.
REQ-033 hi_mark=4, lo_mark=6, level=5, dwell=0 -> HIGH chosen (hi_q priority); clr asserted on the same edge as entry -> irq=1.
REQ-034 Assert rst_n=0 asynchronously while in LOW with streak=2 -> state=00 and irq=0 immediately, without a clock edge.
REQ-035 PEAK_EN: levels 3,9,5, then clr -> peak reads 9 then 0; PEAK_EN undefined build elaborates without the peak port.

Source files
------------

// File: rtl/level_monitor.sv
// -----------------------------------------------------------------------------
// level_monitor
//
// Watches an occupancy level stream and classifies it as MID, HIGH or LOW.
// Hysteresis comes from two watermarks. Persistence comes from a dwell count:
// a transition needs dwell+1 consecutive qualifying accepted samples. Every
// entry into HIGH or LOW raises a sticky irq, which stays set until clr.
//
// Optional feature: define LEVEL_MONITOR_PEAK_EN to add a peak register and
// its output port. The peak value tracks the largest accepted level and is
// zeroed by clr.
//
// Ports
//   clk          in   1  sole clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   level_valid  in   1  sample qualifier (upstream update strobe)
//   level        in   4  unsigned occupancy sample
//   hi_mark      in   4  high watermark (quasi-static)
//   lo_mark      in   4  low watermark (quasi-static)
//   dwell        in   2  persistence; transition needs dwell+1 samples
//   clr          in   1  clears irq (and peak when enabled)
//   state        out  2  00 MID, 01 HIGH, 10 LOW
//   irq          out  1  sticky event flag
//   peak         out  4  maximum accepted level (LEVEL_MONITOR_PEAK_EN only)
// -----------------------------------------------------------------------------
module level_monitor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       level_valid,
  input  logic [3:0] level,
  input  logic [3:0] hi_mark,
  input  logic [3:0] lo_mark,
  input  logic [1:0] dwell,
  input  logic       clr,
`ifdef LEVEL_MONITOR_PEAK_EN
  output logic [3:0] peak,
`endif
  output logic [1:0] state,
  output logic       irq
);

  typedef enum logic [1:0] {
    ST_MID  = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_t;

  // Streak target: 1 = counting toward HIGH, 0 = toward LOW (from MID) or
  // toward MID (from HIGH/LOW). Since every transition clears the streak, a
  // stale target matters only while in MID.
  localparam logic TGT_HIGH = 1'b1;
  localparam logic TGT_LOW  = 1'b0;

  state_t     r_state;
  logic [1:0] r_streak;
  logic       r_tgt;
  logic       r_irq;

  state_t     w_next_state;
  logic [1:0] w_next_streak;
  logic       w_next_tgt;
  logic       w_next_irq;
  logic       w_qual;
  logic       w_tgt;
  logic [1:0] w_base;
  logic [2:0] w_cnt;
  logic [2:0] w_limit;
  logic       w_enter_event;

  // Next-state / streak / flag logic.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and a latch can never be inferred.
  always_comb begin
    w_next_state  = r_state;
    w_next_streak = r_streak;
    w_next_tgt    = r_tgt;
    w_qual        = 1'b0;
    w_tgt         = TGT_LOW;
    w_base        = 2'd0;
    w_cnt         = 3'd0;
    w_limit       = {1'b0, dwell} + 3'd1;

    if (level_valid) begin
      unique case (r_state)
        ST_MID: begin
          // hi_q takes precedence when the watermarks overlap.
          if (level >= hi_mark) begin
            w_qual = 1'b1;
            w_tgt  = TGT_HIGH;
          end else if (level <= lo_mark) begin
            w_qual = 1'b1;
            w_tgt  = TGT_LOW;
          end
        end
        ST_HIGH: w_qual = (level < hi_mark);
        ST_LOW:  w_qual = (level > lo_mark);
        default: w_qual = 1'b0;
      endcase

      if (!w_qual) begin
        w_next_streak = 2'd0;
      end else begin
        // A change of direction restarts the count before this sample is counted.
        w_base     = (w_tgt != r_tgt) ? 2'd0 : r_streak;
        w_cnt      = {1'b0, w_base} + 3'd1;
        w_next_tgt = w_tgt;
        // Compare with >= so that lowering dwell below the current streak
        // fires on the next qualifying sample.
        if (w_cnt >= w_limit) begin
          w_next_streak = 2'd0;
          if (r_state == ST_MID) begin
            w_next_state = (w_tgt == TGT_HIGH) ? ST_HIGH : ST_LOW;
          end else begin
            w_next_state = ST_MID;
          end
        end else begin
          // w_cnt < w_limit <= 4, so w_cnt <= 3: saturation at 3 is implicit.
          w_next_streak = w_cnt[1:0];
        end
      end
    end

    // An undefined state encoding recovers to MID.
    if (r_state != ST_MID && r_state != ST_HIGH && r_state != ST_LOW) begin
      w_next_state  = ST_MID;
      w_next_streak = 2'd0;
    end
  end

  assign w_enter_event = (w_next_state != r_state) && (w_next_state != ST_MID);

  // Setting irq wins over clr on the same edge.
  always_comb begin
    w_next_irq = r_irq;
    if (w_enter_event) begin
      w_next_irq = 1'b1;
    end else if (clr) begin
      w_next_irq = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // values from before the edge regardless of the order of the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_MID;
      r_streak <= 2'd0;
      r_tgt    <= TGT_LOW;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_streak <= w_next_streak;
      r_tgt    <= w_next_tgt;
      r_irq    <= w_next_irq;
    end
  end

`ifdef LEVEL_MONITOR_PEAK_EN
  logic [3:0] r_peak;

  // An accepted sample on a clr edge restarts the peak at that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= 4'd0;
    end else if (clr) begin
      r_peak <= level_valid ? level : 4'd0;
    end else if (level_valid && (level > r_peak)) begin
      r_peak <= level;
    end
  end

  assign peak = r_peak;
`endif

  assign state = r_state;
  assign irq   = r_irq;

endmodule
